// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types and helpers for the note chart scheduler.
//   - sched_state_e : scheduler FSM states (encoding is visible on state_o)
//   - note_entry_t  : one chart entry {valid, lane, due_time}
//   - KEY_START / KEY_RESET : USB keycodes that start a song / return to idle
//   - sat_add       : saturating unsigned add used by all HUD accumulators
// Build option: SCORE_COMBO_EN (consumed by note_chart_scheduler).
package rhythm_pkg;

    localparam int unsigned DEF_NUM_LANES   = 4;
    localparam int unsigned DEF_CHART_DEPTH = 64;
    localparam int unsigned DEF_TIME_W      = 12;
    localparam int unsigned LANE_W          = $clog2(DEF_NUM_LANES);

    localparam logic [7:0] KEY_START = 8'h2c;
    localparam logic [7:0] KEY_RESET = 8'h01;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StWait  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [LANE_W-1:0]     lane;
        logic [DEF_TIME_W-1:0] due_time;
    } note_entry_t;

    // Returns min(a + b, max_val); the sum is formed one bit wider so it never wraps.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/note_chart_rom.sv
// note_chart_rom: CHART_DEPTH-entry note chart with a registered (synchronous) read port.
// Ports:
//   frame_clk_i : clock
//   addr_i      : entry address, sampled every edge
//   entry_o     : entry at the address presented on the previous edge
// Contents come from a constant table so the ROM maps onto block RAM init or LUTs.
// Chart is sorted by ascending due_time; the first invalid entry terminates the song.
import rhythm_pkg::*;

module note_chart_rom #(
    parameter int unsigned CHART_DEPTH = DEF_CHART_DEPTH,
    localparam int unsigned ADDR_W     = $clog2(CHART_DEPTH)
) (
    input  logic              frame_clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output note_entry_t       entry_o
);

    function automatic note_entry_t chart_entry(input logic [ADDR_W-1:0] a);
        note_entry_t e;
        e = '0;
        case (int'(a))
            0:       e = '{valid: 1'b1, lane: 2'd0, due_time: 12'd10};
            1:       e = '{valid: 1'b1, lane: 2'd1, due_time: 12'd10};
            2:       e = '{valid: 1'b1, lane: 2'd2, due_time: 12'd30};
            default: e = '0;
        endcase
        return e;
    endfunction

    note_entry_t entry_q;

    always_ff @(posedge frame_clk_i) begin
        entry_q <= chart_entry(addr_i);
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/note_chart_scheduler.sv
// note_chart_scheduler: walks the note chart, fires one-cycle launch pulses to the arrow
// dropper lanes when the song frame count reaches each note, and accumulates score, combo and
// miss count from the lanes' hit/miss pulses.
// Ports:
//   frame_clk      : sole clock
//   Reset          : asynchronous, active-high reset
//   keycode        : primary USB keycode
//   keycode_second : secondary USB keycode
//   lane_busy      : lane currently holds a falling arrow
//   lane_hit       : one-cycle hit pulses per lane
//   lane_miss      : one-cycle miss pulses per lane
//   launch         : one-cycle launch pulse per lane (only ever high in WAIT)
//   score          : saturating score
//   combo          : consecutive hits, saturating at 255
//   miss_count     : misses plus dropped notes, saturating at 255
//   state_o        : FSM state encoding
//   chart_done     : high while in DONE
// Build option: define SCORE_COMBO_EN to make each hit worth 1 + (combo >> 3).
import rhythm_pkg::*;

module note_chart_scheduler #(
    parameter int unsigned NUM_LANES   = DEF_NUM_LANES,
    parameter int unsigned CHART_DEPTH = DEF_CHART_DEPTH,
    parameter int unsigned TIME_W      = DEF_TIME_W
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [7:0]           keycode,
    input  logic [7:0]           keycode_second,
    input  logic [NUM_LANES-1:0] lane_busy,
    input  logic [NUM_LANES-1:0] lane_hit,
    input  logic [NUM_LANES-1:0] lane_miss,
    output logic [NUM_LANES-1:0] launch,
    output logic [15:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           miss_count,
    output logic [2:0]           state_o,
    output logic                 chart_done
);

    localparam int unsigned ADDR_W = $clog2(CHART_DEPTH);
    // One extra bit so the pointer can reach CHART_DEPTH (end of chart).
    localparam int unsigned PTR_W  = $clog2(CHART_DEPTH + 1);

    sched_state_e      state_q;
    logic [PTR_W-1:0]  ptr_q;
    logic [TIME_W-1:0] frame_q;
    logic              chart_done_q;
    logic [15:0]       score_q, score_d;
    logic [7:0]        combo_q, combo_d;
    logic [7:0]        miss_q, miss_d;

    note_entry_t entry;

    note_chart_rom #(
        .CHART_DEPTH (CHART_DEPTH)
    ) u_rom (
        .frame_clk_i (frame_clk),
        .addr_i      (ptr_q[ADDR_W-1:0]),
        .entry_o     (entry)
    );

    function automatic logic [7:0] popcount(input logic [NUM_LANES-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

    logic key_start, key_reset;
    logic in_run, chart_end, due, fire, drop;

    assign key_start = (keycode == KEY_START) || (keycode_second == KEY_START);
    assign key_reset = (keycode == KEY_RESET) || (keycode_second == KEY_RESET);
    assign in_run    = (state_q == StFetch) || (state_q == StWait) || (state_q == StDrain);
    assign chart_end = !entry.valid || (ptr_q == PTR_W'(CHART_DEPTH));
    assign due       = (frame_q >= entry.due_time);
    // End-of-chart takes priority over any stale entry contents.
    assign fire      = (state_q == StWait) && !chart_end && due && !lane_busy[entry.lane];
    assign drop      = (state_q == StWait) && !chart_end && due && lane_busy[entry.lane];

    // Combinational so the pulse exists only while the FSM sits in WAIT.
    assign launch = fire ? (NUM_LANES'(1) << entry.lane) : '0;

    // Scheduler FSM, chart pointer and frame counter.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            frame_q      <= '0;
            chart_done_q <= 1'b0;
        end else begin
            if (in_run && (frame_q != '1)) begin
                frame_q <= frame_q + TIME_W'(1);
            end
            case (state_q)
                StIdle: begin
                    if (key_start) begin
                        state_q <= StFetch;
                        ptr_q   <= '0;
                        frame_q <= '0;
                    end
                end
                StFetch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (chart_end) begin
                        state_q <= StDrain;
                    end else if (due) begin
                        // Launched or dropped, the note is consumed either way.
                        ptr_q   <= ptr_q + PTR_W'(1);
                        state_q <= StFetch;
                    end
                end
                StDrain: begin
                    if (lane_busy == '0) begin
                        state_q      <= StDone;
                        chart_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (key_reset) begin
                        state_q      <= StIdle;
                        chart_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    chart_done_q <= 1'b0;
                end
            endcase
        end
    end

    // HUD accumulators.
    always_comb begin
        logic [7:0]  hits;
        logic [7:0]  misses;
        logic [31:0] score_add;

        hits   = popcount(lane_hit);
        misses = popcount(lane_miss) + {7'd0, drop};
`ifdef SCORE_COMBO_EN
        // Bonus uses the combo held before this cycle's update.
        score_add = 32'(hits) * (32'd1 + 32'(combo_q >> 3));
`else
        score_add = 32'(hits);
`endif
        score_d = score_q;
        combo_d = combo_q;
        miss_d  = miss_q;

        if (state_q == StIdle) begin
            if (key_start) begin
                score_d = '0;
                combo_d = '0;
                miss_d  = '0;
            end
        end else begin
            score_d = 16'(sat_add(32'(score_q), score_add, 32'h0000_ffff));
            miss_d  = 8'(sat_add(32'(miss_q), 32'(misses), 32'd255));
            // A miss anywhere in the cycle breaks the combo, even alongside hits.
            if (misses != '0) begin
                combo_d = '0;
            end else begin
                combo_d = 8'(sat_add(32'(combo_q), 32'(hits), 32'd255));
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            score_q <= '0;
            combo_q <= '0;
            miss_q  <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            miss_q  <= miss_d;
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign miss_count = miss_q;
    assign state_o    = state_q;
    assign chart_done = chart_done_q;

endmodule
